// File: rtl/skew_sr_pkg.sv
// Shared types and the per-lane delay rule for the skew/deskew shift register.
package skew_sr_pkg;

  typedef enum logic {SKEW, DESKEW} skew_mode_e;

  // Delay in enabled cycles of lane c; SKEW grows with c, DESKEW shrinks with c.
  function automatic int lane_delay(input int c, input int n_ch, input int base,
                                    input int step, input skew_mode_e mode);
    if (mode == SKEW) return base + step * c;
    else              return base + step * (n_ch - 1 - c);
  endfunction

endpackage

// File: rtl/sr_lane.sv
// One lane: DEPTH registered stages carrying valid and data together,
// with global stall (i_en=0) and flush (clears valids, data holds).
module sr_lane #(
  parameter int DEPTH     = 1,
  parameter int DAT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_flush,
  input  logic                 i_dat_vld,
  input  logic [DAT_WIDTH-1:0] i_dat,
  output logic                 o_dat_vld,
  output logic [DAT_WIDTH-1:0] o_dat,
  output logic                 o_any_vld
);

  logic [DEPTH-1:0]     vld_chain;
  logic [DAT_WIDTH-1:0] dat_chain [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic                 vld_in;
    logic [DAT_WIDTH-1:0] dat_in;
    logic                 vld_q, vld_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;

    if (gi == 0) begin : g_head
      assign vld_in = i_dat_vld;
      assign dat_in = i_dat;
    end else begin : g_body
      assign vld_in = vld_chain[gi-1];
      assign dat_in = dat_chain[gi-1];
    end

    // Flush outranks advance; data is left in place so only valids toggle.
    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (i_flush) begin
        vld_d = 1'b0;
      end else if (i_en) begin
        vld_d = vld_in;
        dat_d = dat_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign vld_chain[gi] = vld_q;
    assign dat_chain[gi] = dat_q;
  end

  assign o_dat_vld = vld_chain[DEPTH-1];
  assign o_dat     = dat_chain[DEPTH-1];
  assign o_any_vld = |vld_chain;

endmodule

// File: rtl/skew_sr.sv
// N_CH independent delay lanes whose depth grows (SKEW) or shrinks (DESKEW)
// with the lane index; o_busy reports any valid beat still in flight.
module skew_sr
  import skew_sr_pkg::*;
#(
  parameter int         N_CH       = 4,
  parameter int         DAT_WIDTH  = 16,
  parameter int         BASE_DEPTH = 1,
  parameter int         STEP       = 1,
  parameter skew_mode_e MODE       = SKEW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_en,
  input  logic                           i_flush,
  input  logic [N_CH-1:0]                i_dat_vld,
  input  logic [N_CH-1:0][DAT_WIDTH-1:0] i_dat,
  output logic [N_CH-1:0]                o_dat_vld,
  output logic [N_CH-1:0][DAT_WIDTH-1:0] o_dat,
  output logic                           o_busy
);

  if (BASE_DEPTH < 1 || N_CH < 1 || STEP < 0) begin : g_param_check
    $error("skew_sr: BASE_DEPTH and N_CH must be >= 1, STEP must be >= 0");
  end

  logic [N_CH-1:0] lane_busy;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    localparam int D = lane_delay(gi, N_CH, BASE_DEPTH, STEP, MODE);

    sr_lane #(
      .DEPTH    (D),
      .DAT_WIDTH(DAT_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (i_en),
      .i_flush  (i_flush),
      .i_dat_vld(i_dat_vld[gi]),
      .i_dat    (i_dat[gi]),
      .o_dat_vld(o_dat_vld[gi]),
      .o_dat    (o_dat[gi]),
      .o_any_vld(lane_busy[gi])
    );
  end

  // OR of flop outputs only, so o_busy never glitches within a cycle.
  assign o_busy = |lane_busy;

endmodule

// File: tb/tb_skew_sr.sv
// Checks a SKEW and a DESKEW instance fed identical stimulus against a
// beat-history model indexed by enabled-edge count.
module tb_skew_sr;
  import skew_sr_pkg::*;

  localparam int NC   = 4;
  localparam int W    = 16;
  localparam int BD   = 1;
  localparam int ST   = 1;
  localparam int MAXE = 4096;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               en    = 1'b0;
  logic               flush = 1'b0;
  logic [NC-1:0]      vld   = '0;
  logic [NC-1:0][W-1:0] dat = '0;

  logic [NC-1:0]        vld_s, vld_d;
  logic [NC-1:0][W-1:0] dat_s, dat_d;
  logic                 busy_s, busy_d;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: every accepted beat is logged at its enabled-edge index; flush and
  // reset move the epoch so earlier beats can never be seen again.
  int       ecount   = 0;
  int       epoch    = 0;
  bit       last_adv = 1'b0;
  bit       hist_vld [NC][MAXE];
  logic [W-1:0] hist_dat [NC][MAXE];

  bit           collecting = 1'b0;
  logic [W-1:0] got [$];

  typedef struct {
    bit       en;
    bit       fl;
    logic [3:0] vld;
    logic [3:0] es;
    logic [3:0] ed;
    bit       busy;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  skew_sr #(.N_CH(NC), .DAT_WIDTH(W), .BASE_DEPTH(BD), .STEP(ST), .MODE(SKEW)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_flush(flush), .i_dat_vld(vld), .i_dat(dat),
    .o_dat_vld(vld_s), .o_dat(dat_s), .o_busy(busy_s));

  skew_sr #(.N_CH(NC), .DAT_WIDTH(W), .BASE_DEPTH(BD), .STEP(ST), .MODE(DESKEW)) dut_d (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_flush(flush), .i_dat_vld(vld), .i_dat(dat),
    .o_dat_vld(vld_d), .o_dat(dat_d), .o_busy(busy_d));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch    <= ecount;
      last_adv <= 1'b0;
    end else if (flush) begin
      epoch    <= ecount;
      last_adv <= 1'b0;
    end else if (en) begin
      if (ecount < MAXE) begin
        for (int c = 0; c < NC; c++) begin
          hist_vld[c][ecount] <= vld[c];
          hist_dat[c][ecount] <= dat[c];
        end
      end
      ecount   <= ecount + 1;
      last_adv <= 1'b1;
    end else begin
      last_adv <= 1'b0;
    end
  end

  function automatic int dly(input int c, input skew_mode_e m);
    return lane_delay(c, NC, BD, ST, m);
  endfunction

  function automatic bit exp_vld(input int c, input int d);
    int k = ecount - d;
    if (k < epoch || k >= MAXE) return 1'b0;
    return hist_vld[c][k];
  endfunction

  function automatic logic [W-1:0] exp_dat(input int c, input int d);
    int k = ecount - d;
    if (k < 0 || k >= MAXE) return '0;
    return hist_dat[c][k];
  endfunction

  function automatic bit exp_busy(input skew_mode_e m);
    for (int c = 0; c < NC; c++) begin
      int lo = ecount - dly(c, m);
      if (lo < epoch) lo = epoch;
      for (int j = lo; j < ecount && j < MAXE; j++)
        if (hist_vld[c][j]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NC-1:0] es, ed;
    for (int c = 0; c < NC; c++) begin
      es[c] = exp_vld(c, dly(c, SKEW));
      ed[c] = exp_vld(c, dly(c, DESKEW));
    end
    cmp("skew_vld",  32'(vld_s),  32'(es));
    cmp("dskw_vld",  32'(vld_d),  32'(ed));
    cmp("skew_busy", 32'(busy_s), 32'(exp_busy(SKEW)));
    cmp("dskw_busy", 32'(busy_d), 32'(exp_busy(DESKEW)));
    for (int c = 0; c < NC; c++) begin
      if (es[c]) cmp("skew_dat", 32'(dat_s[c]), 32'(exp_dat(c, dly(c, SKEW))));
      if (ed[c]) cmp("dskw_dat", 32'(dat_d[c]), 32'(exp_dat(c, dly(c, DESKEW))));
      if (!rst_n) begin
        cmp("rst_dat_s", 32'(dat_s[c]), 32'h0);
        cmp("rst_dat_d", 32'(dat_d[c]), 32'h0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (collecting && last_adv && vld_s[2]) got.push_back(dat_s[2]);
  endtask

  task automatic set_dat(input logic [W-1:0] base);
    for (int c = 0; c < NC; c++) dat[c] = base + W'(c);
  endtask

  task automatic idle(input int n);
    en = 1'b1; flush = 1'b0; vld = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic add(input bit e, input bit f, input logic [3:0] v,
                     input logic [3:0] es, input logic [3:0] ed, input bit b);
    vec_t r;
    r.en = e; r.fl = f; r.vld = v; r.es = es; r.ed = ed; r.busy = b;
    tbl.push_back(r);
  endtask

  initial begin
    int cnt;
    int guard;

    // Reset held with random inputs: outputs must stay at zero.
    for (int i = 0; i < 5; i++) begin
      en = 1'($urandom); flush = 1'($urandom); vld = 4'($urandom);
      for (int c = 0; c < NC; c++) dat[c] = W'($urandom);
      tick();
      cmp("rst_vld_s", 32'(vld_s), 32'h0);
      cmp("rst_busy_s", 32'(busy_s), 32'h0);
    end
    rst_n = 1'b1;
    idle(6);

    // Single beat on every lane.
    add(1,0,4'hF,4'h1,4'h8,1); add(1,0,4'h0,4'h2,4'h4,1);
    add(1,0,4'h0,4'h4,4'h2,1); add(1,0,4'h0,4'h8,4'h1,1);
    add(1,0,4'h0,4'h0,4'h0,0);
    // Three stall cycles after edge 1; beats offered while stalled are dropped.
    add(1,0,4'hF,4'h1,4'h8,1); add(1,0,4'h0,4'h2,4'h4,1);
    add(0,0,4'hF,4'h2,4'h4,1); add(0,0,4'hF,4'h2,4'h4,1); add(0,0,4'hF,4'h2,4'h4,1);
    add(1,0,4'h0,4'h4,4'h2,1); add(1,0,4'h0,4'h8,4'h1,1);
    add(1,0,4'h0,4'h0,4'h0,0);
    // Flush on edge 2 while streaming; the beat offered with it never appears.
    add(1,0,4'hF,4'h1,4'h8,1); add(1,0,4'hF,4'h3,4'hC,1);
    add(1,1,4'hF,4'h0,4'h0,0); add(1,0,4'h0,4'h0,4'h0,0);
    add(0,0,4'h0,4'h0,4'h0,0); add(1,0,4'h0,4'h0,4'h0,0);
    add(1,0,4'hF,4'h1,4'h8,1); add(1,0,4'h0,4'h2,4'h4,1);
    add(1,0,4'h0,4'h4,4'h2,1); add(1,0,4'h0,4'h8,4'h1,1);
    add(1,0,4'h0,4'h0,4'h0,0);
    // Flush while stalled still clears valids.
    add(1,0,4'hF,4'h1,4'h8,1); add(0,1,4'hF,4'h0,4'h0,0);
    add(1,0,4'h0,4'h0,4'h0,0); add(1,0,4'h0,4'h0,4'h0,0);

    set_dat(16'h0010);
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; flush = tbl[i].fl; vld = tbl[i].vld;
      tick();
      cmp($sformatf("tbl%0d_vld_s", i), 32'(vld_s), 32'(tbl[i].es));
      cmp($sformatf("tbl%0d_vld_d", i), 32'(vld_d), 32'(tbl[i].ed));
      cmp($sformatf("tbl%0d_busy", i), 32'(busy_s), 32'(tbl[i].busy));
      for (int c = 0; c < NC; c++)
        if (tbl[i].es[c]) cmp($sformatf("tbl%0d_dat%0d", i, c), 32'(dat_s[c]), 32'h10 + 32'(c));
    end
    idle(5);

    // Mid-flight reset on the deskew instance, then a fresh beat.
    en = 1'b1; vld = 4'hF; set_dat(16'h00A0);
    tick(); cmp("mr_e0", 32'(vld_d), 32'h8);
    vld = '0;
    tick(); cmp("mr_e1", 32'(vld_d), 32'h4);
    rst_n = 1'b0;
    #1;
    cmp("mr_async_vld", 32'(vld_d), 32'h0);
    cmp("mr_async_busy", 32'(busy_d), 32'h0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("mr_quiet_vld", 32'(vld_d), 32'h0);
      cmp("mr_quiet_busy", 32'(busy_d), 32'h0);
    end
    vld = 4'hF; set_dat(16'h00B0);
    tick(); cmp("mr_new0", 32'(vld_d), 32'h8); cmp("mr_new0_dat", 32'(dat_d[3]), 32'hB3);
    vld = '0;
    tick(); cmp("mr_new1", 32'(vld_d), 32'h4); cmp("mr_new1_dat", 32'(dat_d[2]), 32'hB2);
    tick(); cmp("mr_new2", 32'(vld_d), 32'h2);
    tick(); cmp("mr_new3", 32'(vld_d), 32'h1); cmp("mr_new3_dat", 32'(dat_d[0]), 32'hB0);
    tick(); cmp("mr_new4", 32'(busy_d), 32'h0);

    // Random traffic, stalls and flushes against the model.
    for (int i = 0; i < 300; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      vld   = 4'($urandom);
      for (int c = 0; c < NC; c++) dat[c] = W'($urandom);
      tick();
    end
    idle(6);

    // Lane 2 streams a counter under random stalls.
    collecting = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 100 && guard < 3000) begin
      en = ($urandom_range(0, 2) != 0); flush = 1'b0;
      vld = 4'($urandom); vld[2] = 1'b1;
      for (int c = 0; c < NC; c++) dat[c] = W'($urandom);
      dat[2] = W'(cnt);
      tick();
      if (en) cnt++;
      guard++;
    end
    idle(8);
    collecting = 1'b0;
    cmp("stream_len", 32'(got.size()), 32'd100);
    for (int i = 0; i < got.size() && i < 100; i++)
      cmp($sformatf("stream_%0d", i), 32'(got[i]), 32'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/skew_sr.md
SKEW_SR -- requirements
Module: skew_sr

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent lanes.
REQ-002 The block SHALL have parameter DAT_WIDTH, default 16: data bits per lane.
REQ-003 The block SHALL have parameter BASE_DEPTH, default 1: minimum lane delay in cycles; legal range is 1 or more.
REQ-004 The block SHALL have parameter STEP, default 1: extra delay per lane index; legal range is 0 or more.
REQ-005 The block SHALL have parameter MODE, default SKEW: SKEW gives delay D(c)=BASE_DEPTH+STEP*c; DESKEW gives D(c)=BASE_DEPTH+STEP*(N_CH-1-c).
REQ-006 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port i_en, input, 1 bit: global advance; 0 stalls all lanes.
REQ-009 The block SHALL have port i_flush, input, 1 bit: synchronous invalidate of all in-flight beats.
REQ-010 The block SHALL have port i_dat_vld, input, N_CH bits: per-lane input valid.
REQ-011 The block SHALL have port i_dat, input, N_CH x DAT_WIDTH bits: per-lane input data.
REQ-012 The block SHALL have port o_dat_vld, output, N_CH bits: per-lane output valid.
REQ-013 The block SHALL have port o_dat, output, N_CH x DAT_WIDTH bits: per-lane output data.
REQ-014 The block SHALL have port o_busy, output, 1 bit: 1 while any lane holds a valid beat in any stage.

Function
REQ-015 Lane c SHALL be a chain of D(c) registered stages (valid plus data); o_dat_vld[c] and o_dat[c] are driven directly by the last stage, with no combinational path from input to output.
REQ-016 On an edge with i_en=1 and i_flush=0, every stage SHALL load from its predecessor, and stage 0 SHALL load i_dat_vld[c] and i_dat[c].
REQ-017 On an edge with i_en=0 and i_flush=0, all stages SHALL hold; inputs presented on that edge are discarded.
REQ-018 Latency SHALL be counted in enabled edges: a beat accepted on enabled edge k appears at the output after enabled edge k+D(c)-1, independent of stall cycles in between.
REQ-019 Data and valid SHALL travel together: a stall never separates, duplicates or drops a beat.
REQ-020 Inputs with i_dat_vld[c]=0 SHALL still shift data through; verification checks only beats with valid=1.
REQ-021 On an edge with i_flush=1, all valid bits SHALL clear regardless of i_en, and data registers SHALL hold.
REQ-022 Input beats presented on a flush edge SHALL be discarded.
REQ-023 o_busy SHALL be the OR of all valid stage bits; it is registered-derived and glitch-free relative to clk.
REQ-024 Back-to-back valid beats on one lane SHALL emerge on consecutive enabled cycles, giving full throughput of one beat per lane per enabled cycle.
REQ-025 When STEP=0, all lanes SHALL have equal delay BASE_DEPTH, making the block a plain N_CH-wide delay line with stall and flush.

Reset
REQ-026 While rst_n=0, all valid and data stages SHALL be 0 asynchronously, so o_dat_vld=0, o_dat=0 and o_busy=0.
REQ-027 Reset asserted mid-flight SHALL discard all beats; after release, the first accepted beat SHALL obey REQ-018 from that point.
REQ-028 Reset deassertion is synchronised outside this block; the first edge after release SHALL be treated as a normal edge.

Structure
REQ-029 Package skew_sr_pkg SHALL hold: enum skew_mode_e {SKEW, DESKEW}, and function lane_delay(c, n_ch, base, step, mode) returning D(c), which is used by both the RTL and the bench.
REQ-030 Each lane SHALL be one instance of sub-module sr_lane, parameterised by DEPTH and DAT_WIDTH with ports clk, rst_n, i_en, i_flush, i_dat_vld, i_dat, o_dat_vld, o_dat and o_any_vld; instances are created in a generate loop over c.
REQ-031 An elaboration-time check SHALL reject BASE_DEPTH<1 and N_CH<1.

Verification
Bench configuration: N_CH=4, DAT_WIDTH=16, BASE_DEPTH=1, STEP=1, MODE=SKEW unless noted.
REQ-032 Reset scenario: rst_n=0 with random inputs -> o_dat_vld=0000, o_dat=0, o_busy=0 throughout.
REQ-033 Skew scenario: one beat on all lanes at enabled edge 0, data 0x0010+c -> lane c valid for exactly one cycle after edge c, showing 0x0010+c; o_busy falls after edge 4.
REQ-034 Stall scenario: as REQ-033, with i_en=0 for 3 cycles after edge 1 -> lanes 2 and 3 arrive 3 cycles later, data intact, no duplicate valids.
REQ-035 Flush scenario: stream on all lanes, i_flush=1 at edge 2 -> no valid output after edge 2 until new input; o_busy=0 after edge 2; a beat offered at edge 2 is not seen.
REQ-036 Deskew and mid-flight reset scenario: MODE=DESKEW with a beat at edge 0 -> lane 3 out after edge 0 and lane 0 out after edge 3; rerun with rst_n pulsed at edge 1 -> no outputs, then the next beat obeys REQ-018.
REQ-037 Streaming scenario: continuous valid counter data 0..99 on lane 2 with random i_en -> output sequence is exactly 0..99, in order, with no gaps in enabled cycles.
